sdram_burst_bank: RTL
=====================

# sdram_burst_bank

Parametrised behavioural SDRAM device model for the parallel-bus SDRAM interface testbench and integration builds. It decodes the raw bar_CS/bar_RAS/bar_CAS/bar_WE command bus and tracks an open row per bank. It runs fixed-length sequential write and read bursts with wrap inside the burst block, and returns read data after a programmable CAS latency. It replaces the single-mode counter-addressed bank store with a real command interface.

## Interface
- DATA_W, 32, data bus width
- BANKS, 4, bank count (power of two); BANK_W = log2(BANKS)
- ROW_W, 10, row address width; also width of A
- COL_W, 4, column width; COL_W <= ROW_W-1
- BURST_LEN, 8, beats per burst (power of two, <= 2^COL_W)
- CAS_LAT, 2, read latency in cycles (1..3)
- clock  in  1  sole clock; all logic on rising edge
- bar_reset  in  1  synchronous, active-low reset
- bar_CS, bar_RAS, bar_CAS, bar_WE  in  1 each  command bus, active-low
- BS  in  BANK_W  bank select
- A  in  ROW_W  row (ACTIVE) / column in A[COL_W-1:0] (READ/WRITE) / A[ROW_W-1] = all-banks (PRECHARGE)
- WData  in  DATA_W  write data
- RData  out  DATA_W  read data
- RValid  out  1  RData holds a burst beat this cycle
- Bank_open  out  BANKS  per-bank row-open flags
- Cmd_err  out  1  one-cycle pulse on an illegal command

## Operation
- Command code {CS,RAS,CAS,WE}: bar_CS=1 or 0111 NOP; 0011 ACTIVE; 0101 READ; 0100 WRITE; 0010 PRECHARGE; 0110 BURST_STOP. All other codes are treated as NOP.
- ACTIVE to a closed bank latches row A and sets Bank_open[BS]. ACTIVE to an open bank asserts Cmd_err; row is unchanged.
- PRECHARGE clears Bank_open[BS], or all banks if A[ROW_W-1]=1. It terminates the active burst if that burst targets a closed bank.
- READ/WRITE to a closed bank asserts Cmd_err and is ignored; a running burst continues.
- Burst FSM states: IDLE, WR_BURST, RD_BURST.
  - Legal READ/WRITE from any state starts a new burst, truncating the current one.
  - After BURST_LEN beats, or on BURST_STOP, the FSM returns to IDLE.
- Beat i column = {col[COL_W-1:LB], (col[LB-1:0]+i) mod BURST_LEN}, with LB = log2(BURST_LEN). The column wraps inside the aligned block and never carries into upper bits.
- Write: WData is stored on the command edge (beat 0) and on each following edge through beat BURST_LEN-1. Storage location is [bank][open row][beat column].
- Read: beat i is fetched at edge t+i. It appears on RData with RValid=1 after edge t+i+CAS_LAT.
  - Beats already fetched still emerge after truncation, stop or precharge.
  - RValid and RData are independent of later write traffic.
- Memory contents are not initialised and are not cleared by reset. Reading unwritten locations returns X.

## Timing
- Reset values: RData=0, RValid=0, Bank_open=0, Cmd_err=0, FSM=IDLE, read pipe flushed.
- Reset asserted mid-burst aborts immediately. No beats are written or returned after the reset edge.
- Write latency is 0. Read latency is CAS_LAT cycles from the command edge to the first RData-valid edge.
- Gapless bursts: a READ issued on the last beat of a previous read burst gives continuous RValid.
- Cmd_err is registered and high for exactly the cycle after the offending command.
- ACTIVE and PRECHARGE on the same edge as a burst beat take effect at that edge. The beat on that edge uses the pre-edge row state.

## Structure
- Package sdram_pkg holds:
  - command encoding constants
  - burst state enum
  - a function computing the wrapped beat column from (base column, beat index, LB)
- Sub-module sdram_rd_pipe: CAS_LAT-deep {valid, data} delay line with synchronous flush on bar_reset. It is instantiated once.
- Top level holds the command decode, open-row registers, burst FSM/counter and memory array.

## Test plan
- Defaults: ACTIVE bank 1 row 5; WRITE col 3 with data 0x100..0x107; READ col 3 -> RValid rises 2 cycles after READ; RData = 0x100..0x107 on 8 consecutive cycles; cols written in order 3,4,5,6,7,0,1,2.
- READ to closed bank 2 -> Cmd_err one cycle; RValid stays 0; ACTIVE to open bank 1 -> Cmd_err; row stays 5.
- Read burst, then a new READ at beat 3 -> 3 old beats followed back-to-back by 8 new beats; RValid never drops.
- BURST_STOP at write beat 4 -> only cols 3..6 updated; later read shows old contents at 7,0,1,2.
- PRECHARGE with A[ROW_W-1]=1 -> Bank_open=0; in-flight read beats still delivered; a subsequent WRITE raises Cmd_err.
- bar_reset low mid read burst -> next cycle RValid=0, RData=0, Bank_open=0; memory contents are retained after re-ACTIVE.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM burst bank model: command codes,
// burst state encoding and the wrapped burst column helper.
package sdram_pkg;

  // {bar_CS, bar_RAS, bar_CAS, bar_WE}
  localparam logic [3:0] CMD_NOP        = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
  localparam logic [3:0] CMD_READ       = 4'b0101;
  localparam logic [3:0] CMD_WRITE      = 4'b0100;
  localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;
  localparam logic [3:0] CMD_BURST_STOP = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_BURST,
    ST_RD_BURST
  } burst_state_e;

  // Column of a burst beat: the low lb bits count modulo the burst length
  // and never carry into the upper (block-select) bits of the base column.
  function automatic logic [31:0] wrapCol(input logic [31:0] baseCol,
                                          input logic [31:0] beatIdx,
                                          input int          lb);
    logic [31:0] mask;
    mask = (32'd1 << lb) - 32'd1;
    return (baseCol & ~mask) | ((baseCol + beatIdx) & mask);
  endfunction

endpackage

// File: rtl/sdram_rd_pipe.sv
// CAS-latency delay line carrying {valid, data} from the memory fetch
// register to the read data outputs. Flushed synchronously by bar_reset.
module sdram_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              bar_reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid [DEPTH];
  logic [DATA_W-1:0] r_data  [DEPTH];

  // Shift fetched beats one stage per cycle; reset empties every stage.
  always_ff @(posedge clock) begin
    if (!bar_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_data[i]  <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/sdram_burst_bank.sv
// Behavioural SDRAM device model: decodes the raw command bus, tracks an
// open row per bank, runs wrapped fixed-length write/read bursts and returns
// read data after CAS_LAT cycles through sdram_rd_pipe.
module sdram_burst_bank
  import sdram_pkg::*;
#(
  parameter int  DATA_W    = 32,
  parameter int  BANKS     = 4,
  parameter int  ROW_W     = 10,
  parameter int  COL_W     = 4,
  parameter int  BURST_LEN = 8,
  parameter int  CAS_LAT   = 2,
  localparam int BANK_W    = $clog2(BANKS)
) (
  input  logic              clock,
  input  logic              bar_reset,
  input  logic              bar_CS,
  input  logic              bar_RAS,
  input  logic              bar_CAS,
  input  logic              bar_WE,
  input  logic [BANK_W-1:0] BS,
  input  logic [ROW_W-1:0]  A,
  input  logic [DATA_W-1:0] WData,
  output logic [DATA_W-1:0] RData,
  output logic              RValid,
  output logic [BANKS-1:0]  Bank_open,
  output logic              Cmd_err
);

  localparam int LB        = $clog2(BURST_LEN);
  localparam int BEAT_W    = (LB > 0) ? LB : 1;
  localparam int ADDR_W    = BANK_W + ROW_W + COL_W;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  // Command decode
  logic [3:0] w_cmd;
  logic       w_isActive, w_isRead, w_isWrite, w_isPre, w_isStop;
  logic       w_bankOpen, w_startRd, w_startWr, w_errNext, w_preHits;

  // Burst control
  burst_state_e      r_state, w_stateNext;
  logic [BANK_W-1:0] r_bank;
  logic [COL_W-1:0]  r_baseCol;
  logic [BEAT_W-1:0] r_beat;
  logic              w_beatActive;
  logic [COL_W-1:0]  w_beatCol;

  // Open-row tracking
  logic [ROW_W-1:0] r_row [BANKS];
  logic [BANKS-1:0] r_open;
  logic             r_cmdErr;

  // Memory access for this edge
  logic              w_wrEn, w_rdEn;
  logic [BANK_W-1:0] w_bank;
  logic [COL_W-1:0]  w_col;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] r_mem [MEM_DEPTH];
  logic              r_fetchValid;
  logic [DATA_W-1:0] r_fetchData;

  assign w_cmd      = {bar_CS, bar_RAS, bar_CAS, bar_WE};
  assign w_isActive = (w_cmd == CMD_ACTIVE);
  assign w_isRead   = (w_cmd == CMD_READ);
  assign w_isWrite  = (w_cmd == CMD_WRITE);
  assign w_isPre    = (w_cmd == CMD_PRECHARGE);
  assign w_isStop   = (w_cmd == CMD_BURST_STOP);
  assign w_bankOpen = r_open[BS];
  assign w_startRd  = w_isRead  && w_bankOpen;
  assign w_startWr  = w_isWrite && w_bankOpen;
  assign w_errNext  = (w_isActive && w_bankOpen) ||
                      ((w_isRead || w_isWrite) && !w_bankOpen);
  assign w_preHits  = w_isPre && (A[ROW_W-1] || (BS == r_bank));

  // A running burst performs a beat unless stopped or replaced this edge;
  // a precharge still lets the beat on its own edge through.
  assign w_beatActive = (r_state != ST_IDLE) && !w_isStop && !w_startWr && !w_startRd;
  assign w_beatCol    = COL_W'(wrapCol(32'(r_baseCol), 32'(r_beat), LB));

  // Burst state register
  always_ff @(posedge clock) begin
    if (!bar_reset) r_state <= ST_IDLE;
    else            r_state <= w_stateNext;
  end

  // Next burst state: new commands truncate, stop/precharge/last beat end
  always_comb begin
    w_stateNext = r_state;
    if (w_startWr) begin
      w_stateNext = (BURST_LEN > 1) ? ST_WR_BURST : ST_IDLE;
    end else if (w_startRd) begin
      w_stateNext = (BURST_LEN > 1) ? ST_RD_BURST : ST_IDLE;
    end else if (r_state != ST_IDLE) begin
      if (w_isStop || w_preHits || (r_beat == BEAT_W'(BURST_LEN - 1)))
        w_stateNext = ST_IDLE;
    end
  end

  // Memory access selection: beat 0 comes from the command, later beats from the counter
  always_comb begin
    w_wrEn = 1'b0;
    w_rdEn = 1'b0;
    w_bank = r_bank;
    w_col  = w_beatCol;
    if (w_startWr || w_startRd) begin
      w_bank = BS;
      w_col  = A[COL_W-1:0];
      w_wrEn = w_startWr;
      w_rdEn = w_startRd;
    end else if (w_beatActive) begin
      w_wrEn = (r_state == ST_WR_BURST);
      w_rdEn = (r_state == ST_RD_BURST);
    end
  end

  assign w_addr = {w_bank, r_row[w_bank], w_col};

  // Burst bookkeeping: target bank, base column and index of the next beat
  always_ff @(posedge clock) begin
    if (!bar_reset) begin
      r_bank    <= '0;
      r_baseCol <= '0;
      r_beat    <= '0;
    end else if (w_startWr || w_startRd) begin
      r_bank    <= BS;
      r_baseCol <= A[COL_W-1:0];
      r_beat    <= BEAT_W'(1);
    end else if (w_beatActive) begin
      r_beat    <= r_beat + BEAT_W'(1);
    end
  end

  // Open-row registers updated by ACTIVE and PRECHARGE
  always_ff @(posedge clock) begin
    if (!bar_reset) begin
      r_open <= '0;
      for (int i = 0; i < BANKS; i++) r_row[i] <= '0;
    end else if (w_isActive && !w_bankOpen) begin
      r_row[BS]  <= A;
      r_open[BS] <= 1'b1;
    end else if (w_isPre) begin
      if (A[ROW_W-1]) r_open     <= '0;
      else            r_open[BS] <= 1'b0;
    end
  end

  // Registered one-cycle error pulse for illegal commands
  always_ff @(posedge clock) begin
    if (!bar_reset) r_cmdErr <= 1'b0;
    else            r_cmdErr <= w_errNext;
  end

  // Storage array: never reset, and no write lands on a reset edge
  always_ff @(posedge clock) begin
    if (bar_reset && w_wrEn) r_mem[w_addr] <= WData;
  end

  // Fetch register capturing the beat read on this edge
  always_ff @(posedge clock) begin
    if (!bar_reset) begin
      r_fetchValid <= 1'b0;
      r_fetchData  <= '0;
    end else begin
      r_fetchValid <= w_rdEn;
      r_fetchData  <= w_rdEn ? r_mem[w_addr] : '0;
    end
  end

  sdram_rd_pipe #(
    .DATA_W (DATA_W),
    .DEPTH  (CAS_LAT)
  ) u_rdPipe (
    .clock     (clock),
    .bar_reset (bar_reset),
    .i_valid   (r_fetchValid),
    .i_data    (r_fetchData),
    .o_valid   (RValid),
    .o_data    (RData)
  );

  assign Bank_open = r_open;
  assign Cmd_err   = r_cmdErr;

endmodule
